sync_tx_arbiter: RTL
====================

// Module: sync_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one transmitter-side synchronizer channel among
//  N producers in the transmit clock domain.
//  - Selects a requester and latches its word.
//  - Presents the word on v/out_data and holds it until the channel accepts it
//    (f low), then acks the winner.
//  - Flags a stalled channel with a sticky timeout error and counts sent words.
// PARAMETERS
//  DATA_MSB     7    MSB of one data word (word width DATA_MSB+1)
//  N            4    number of requesters (2..8)
//  IDW          2    width of grant_id, = clog2(N)
//  TIMEOUT_CYC  255  cycles in SEND with f=1 before timeout_err sets (1..65535)
// PORTS
//  clk          in   1                  transmit-domain clock
//  reset        in   1                  asynchronous, active-high reset
//  en           in   1                  1 = arbitration allowed
//  req_v        in   N                  per-requester word valid, level
//  req_data     in   N*(DATA_MSB+1)     packed words, requester i at bits [i*(DATA_MSB+1) +: DATA_MSB+1]
//  req_ack      out  N                  one-cycle pulse: requester i's word accepted
//  grant_id     out  IDW                index of current/last winner
//  v            out  1                  word valid to synchronizer transmitter
//  out_data     out  DATA_MSB+1         word to synchronizer transmitter
//  f            in   1                  transmitter full/busy; word accepted on edge where v=1 & f=0
//  busy         out  1                  1 whenever state != IDLE
//  timeout_err  out  1                  sticky stall flag
//  words_sent   out  16                 accepted-word counter
// BEHAVIOUR
//  Reset (async)
//  - All outputs 0; state=IDLE; rr pointer=0; holding register=0.
//  - Any in-flight word is dropped with no ack.
//  FSM
//  - IDLE: v=0. If en=1, f=0 and any req_v: pick winner, latch
//    req_data[winner] into out_data, set grant_id=winner, go SEND.
//  - SEND: v=1; out_data and grant_id held stable.
//    If f=0 at the edge: word accepted; req_ack[grant_id] pulses high the
//    next cycle; go HOLD. Otherwise stay in SEND.
//  - HOLD: v=0 for exactly 1 cycle, so f can rise before re-arbitration.
//    Always goes to IDLE.
//  Arbitration
//  - Search starts at rr pointer and wraps modulo N; first set req_v wins.
//  - rr pointer becomes (winner+1) mod N on acceptance only.
//  Latency
//  - req_v seen in IDLE at edge k: v=1 from k to k+1.
//  - With f=0, acceptance at edge k+1; req_ack high from k+1 to k+2.
//  - Minimum 3 cycles per word.
//  Requester rules
//  - Hold req_v and data until ack.
//  - req_v still high in the cycle after ack is a new request.
//  - Dropping req_v before grant withdraws the request with no effect.
//  - Dropping req_v after grant has no effect: the word is already latched.
//  Enable
//  - en=0 blocks new grants only.
//  - A transfer in SEND or HOLD always completes.
//  Timeout
//  - 16-bit stall counter: increments each SEND cycle with f=1; clears on
//    leaving SEND.
//  - When counter == TIMEOUT_CYC, timeout_err sets and stays set until reset.
//  - The transfer is not aborted.
//  words_sent
//  - +1 per acceptance; wraps 0xFFFF -> 0x0000.
//  Boundaries
//  - Only one requester active: it wins every round.
//  - All N requesting: strict rotation.
//  - f=1 in IDLE: no grant.
//  - req_ack never pulses for more than one cycle or more than one bit.
// TESTING
//  1. Single: reset, en=1, f=0, req_v=4'b0100, data2=8'hA5 ->
//     v=1 out_data=A5 grant_id=2 for 1 cycle; req_ack=4'b0100 next cycle;
//     words_sent=1.
//  2. Fairness: req_v=4'b1111 held, f=0, 8 words ->
//     grant order 0,1,2,3,0,1,2,3; each ack spaced 3 cycles.
//  3. Backpressure: grant 1 while f=1 for 10 cycles ->
//     v and out_data stable 10 cycles; ack on the first cycle after f=0;
//     timeout_err=0.
//  4. Timeout: TIMEOUT_CYC=4, f=1 held in SEND ->
//     timeout_err=1 after 4 stalled cycles; stays 1 after f=0 and the ack.
//  5. Reset mid-SEND: assert reset while v=1 ->
//     v, req_ack, grant_id, words_sent=0 immediately; no ack;
//     the next grant starts at requester 0.
//  6. en=0 during SEND -> current word completes and acks; no further grant
//     until en=1; counter wrap from 0xFFFF -> 0 on the next acceptance.

Source files
------------

// File: rtl/sync_tx_arbiter.sv
// Round-robin arbiter that shares one synchronizer transmitter among N producers.
// A winner's word is latched, presented on v/out_data until accepted, then acked.
module sync_tx_arbiter #(
  parameter int DATA_MSB    = 7,
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N-1:0]              req_v,
  input  logic [N*(DATA_MSB+1)-1:0] req_data,
  output logic [N-1:0]              req_ack,
  output logic [IDW-1:0]            grant_id,
  output logic                      v,
  output logic [DATA_MSB:0]         out_data,
  input  logic                      f,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [15:0]               words_sent
);

  localparam int W = DATA_MSB + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_next;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic [IDW:0]     cand;
  logic [15:0]      stall_cnt;
  logic [15:0]      stall_next;
  logic [DATA_MSB:0] req_words [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_words[g] = req_data[g*W +: W];
  end

  // First active requester at or after the rr pointer, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!win_found && req_v[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  assign rr_next    = (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);
  assign stall_next = stall_cnt + 16'd1;

  assign v    = (state == ST_SEND);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      out_data    <= '0;
      req_ack     <= '0;
      words_sent  <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        ST_IDLE: begin
          stall_cnt <= '0;
          if (en && !f && win_found) begin
            grant_id <= win_idx;
            out_data <= req_words[win_idx];
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!f) begin
            req_ack    <= N'(1) << grant_id;
            words_sent <= words_sent + 16'd1;
            rr_ptr     <= rr_next;
            stall_cnt  <= '0;
            state      <= ST_HOLD;
          end else begin
            // Saturate so a very long stall can never wrap back below the threshold.
            if (stall_cnt != 16'hFFFF) begin
              stall_cnt <= stall_next;
            end
            if (stall_next == 16'(TIMEOUT_CYC)) begin
              timeout_err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          stall_cnt <= '0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
